maple_rx_packet_ctrl: RTL
=========================

# maple_rx_packet_ctrl

Sequences the Maple bus receive path. It consumes the byte stream and `frame` qualifier from the receiver, assembles bytes into 32-bit words, and validates the header length and XOR CRC. Words go into a commit/rollback word FIFO, and a packet becomes visible on a ready/valid output only after it passes every check. It sits between `receiver` and the host/DMA side, and discards malformed frames.

## Interface
Parameters:
- `ADDR_WIDTH`, default 9: log2 of the FIFO depth in words. Usable capacity is 2^ADDR_WIDTH words.

Ports:
- `clk`, in, 1: sole clock.
- `reset`, in, 1: synchronous, active-high.
- `frame`, in, 1: high while the receiver is inside a frame.
- `data_ready`, in, 1: single-cycle strobe, `data` valid.
- `data`, in, 8: received byte.
- `out_valid`, out, 1: a committed word is available.
- `out_ready`, in, 1: consumer accepts the word.
- `out_data`, out, 32: committed word.
- `out_last`, out, 1: last word of a packet.
- `pkt_done`, out, 1: one-cycle pulse when a frame ends, good or bad.
- `pkt_ok`, out, 1: result of the last frame. Held until the next `pkt_done`.
- `err_crc`, out, 1: CRC mismatch. Held like `pkt_ok`.
- `err_len`, out, 1: frame ended early, or extra bytes arrived. Held like `pkt_ok`.
- `err_ovf`, out, 1: FIFO full during the frame. Held like `pkt_ok`.
- `busy`, out, 1: state is not IDLE.

## Operation
- Byte order: the first byte of each word lands in [7:0], the fourth in [31:24].
- Header word (word 0):
  - [7:0] = N, the additional word count.
  - [15:8] = source.
  - [23:16] = destination.
  - [31:24] = command.
  - Expected words = N+1. The final byte of the frame is the CRC.
- CRC = XOR of all 4(N+1) packet bytes. It must equal the CRC byte.
- States: IDLE, WORDS, CRC, WAIT_END, DISCARD.
  - IDLE: when `frame`=1, go to WORDS. Clear the byte index (2 bits), word count, and running CRC.
  - WORDS, on each `data_ready`:
    - Shift the byte in, XOR it into the CRC, and increment the byte index.
    - On the 4th byte, write {last, word} at `wr_ptr` and increment `wr_ptr`. `last`=1 when this is word N.
    - N is captured from byte 0 of word 0.
    - After word N, go to CRC.
  - CRC, on `data_ready`:
    - Byte matches the running CRC: go to WAIT_END.
    - Otherwise set `err_crc` and go to DISCARD.
  - WAIT_END:
    - `frame`=0: commit (`commit_ptr`←`wr_ptr`), pulse `pkt_done` with `pkt_ok`=1, and go to IDLE.
    - `data_ready` while `frame`=1: set `err_len` and go to DISCARD.
  - `frame`=0 while in WORDS or CRC: set `err_len`, roll back (`wr_ptr`←`commit_ptr`), pulse `pkt_done` with `pkt_ok`=0, and go to IDLE.
  - DISCARD: ignore all bytes. On `frame`=0, roll back, pulse `pkt_done` with `pkt_ok`=0, and go to IDLE.
- Overflow: a word write when the FIFO is full sets `err_ovf` and goes to DISCARD. The write is dropped.
  - Full: `wr_ptr` − `rd_ptr` = 2^ADDR_WIDTH, using (ADDR_WIDTH+1)-bit pointers.
- Error flags accumulate during a frame and are all cleared when the next frame starts.
- `data_ready` while `frame`=0 is ignored in every state.
- Read side:
  - `out_valid` = (`rd_ptr` ≠ `commit_ptr`).
  - When `out_valid` and `out_ready` are both high, increment `rd_ptr`.
  - Uncommitted words are never readable.
  - Reads and writes proceed independently in the same cycle.

## Timing
- Reset values: all outputs 0. State = IDLE. All pointers = 0, which discards any partial or committed data.
- Reset mid-frame: return to IDLE. A frame that is still high after reset is treated as a new frame start.
- Byte capture: the byte is registered in the cycle after the `data_ready` strobe. A word write takes effect on the same edge.
- The `frame`=0 sample is edge N.
  - `pkt_done`, status flags, and `commit_ptr` update at edge N+1.
  - `out_valid` can rise at edge N+1.
- `out_data` and `out_last` are read combinationally from the registered memory at `rd_ptr`. They are stable while `out_valid`=1 and `out_ready`=0.
- Input bytes arrive at least 4 cycles apart. There is no backpressure toward the receiver.

## Structure
- `maple_pkg` holds:
  - The state enum.
  - Header field bit positions (count, source, destination, command).
  - A CRC-width constant.
- Sub-module `maple_rx_fifo` implements the commit/rollback FIFO:
  - Storage of 33-bit entries.
  - `wr_ptr`, `commit_ptr`, `rd_ptr`.
  - Commit and rollback inputs, and the full flag.
- The top level holds the FSM, word assembler, CRC, and status registers.

## Test plan
- Good packet, N=1, words 0x01020301 and 0xDEADBEEF, correct CRC, `out_ready`=1:
  - Two words out; `out_last`=1 on the second.
  - `pkt_done`=1 with `pkt_ok`=1, and flags all 0.
- Same packet with the CRC byte XOR 0x01:
  - `err_crc`=1, `pkt_ok`=0.
  - `out_valid` never rises, and `wr_ptr` returns to its prior value.
- N=2 header, but `frame` drops after 1 data word:
  - `err_len`=1, rollback, no output.
  - A following good packet is read out intact.
- Good packet followed by an extra byte before `frame` drops:
  - `err_len`=1, nothing committed.
- `ADDR_WIDTH`=2, `out_ready`=0, good N=1 packet, then an N=3 packet:
  - First packet commits (2 words).
  - Second packet gives `err_ovf`=1.
  - FIFO then drains exactly the 2 first-packet words.
- `reset` pulsed mid-WORDS with a committed word pending:
  - Next cycle: `out_valid`=0 and `busy`=0.
  - `busy`=1 again on the next cycle because `frame` is still high; a subsequent good packet is received correctly.

Source files
------------

// File: rtl/maple_pkg.sv
// Shared types and constants for the Maple bus receive path: FSM states,
// header field layout and FIFO entry geometry.
package maple_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WORDS,
    S_CRC,
    S_WAIT_END,
    S_DISCARD
  } state_t;

  typedef enum logic [1:0] {
    F_COUNT,
    F_SRC,
    F_DST,
    F_CMD
  } hdr_field_t;

  localparam int HDR_COUNT_LSB = 0;
  localparam int HDR_SRC_LSB   = 8;
  localparam int HDR_DST_LSB   = 16;
  localparam int HDR_CMD_LSB   = 24;

  localparam int CRC_W     = 8;
  localparam int WORD_W    = 32;
  localparam int ENTRY_W   = WORD_W + 1;  // {last, word}

  function automatic int hdr_field_lsb(input hdr_field_t f);
    case (f)
      F_COUNT: return HDR_COUNT_LSB;
      F_SRC:   return HDR_SRC_LSB;
      F_DST:   return HDR_DST_LSB;
      default: return HDR_CMD_LSB;
    endcase
  endfunction

endpackage

// File: rtl/maple_rx_fifo.sv
// Commit/rollback word FIFO: writes stay invisible to the reader until
// committed, and an uncommitted tail can be dropped by rolling back.
module maple_rx_fifo
  import maple_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_wr_en,
  input  logic [ENTRY_W-1:0] i_wr_data,
  input  logic               i_commit,
  input  logic               i_rollback,
  input  logic               i_rd_en,
  output logic               o_full,
  output logic               o_valid,
  output logic [ENTRY_W-1:0] o_rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [ENTRY_W-1:0]  r_mem [DEPTH];
  logic [ADDR_WIDTH:0] r_wr_ptr;
  logic [ADDR_WIDTH:0] r_commit_ptr;
  logic [ADDR_WIDTH:0] r_rd_ptr;
  logic                w_do_write;

  assign o_full = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                  (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
  assign o_valid    = (r_rd_ptr != r_commit_ptr);
  assign w_do_write = i_wr_en && !o_full;
  assign o_rd_data  = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

  // NOTE: storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_write) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
    end else begin
      if (i_rollback)      r_wr_ptr <= r_commit_ptr;
      else if (w_do_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_commit)        r_commit_ptr <= r_wr_ptr;
      if (o_valid && i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/maple_rx_packet_ctrl.sv
// Maple bus receive sequencer: assembles bytes into words, checks header
// length and XOR CRC, and only commits packets that pass every check.
module maple_rx_packet_ctrl
  import maple_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame,
  input  logic        data_ready,
  input  logic [7:0]  data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        pkt_done,
  output logic        pkt_ok,
  output logic        err_crc,
  output logic        err_len,
  output logic        err_ovf,
  output logic        busy
);

  localparam logic [1:0] COUNT_BYTE = 2'(hdr_field_lsb(F_COUNT) / 8);

  state_t             r_state;
  logic               r_frame;
  logic [1:0]         r_byte_idx;
  logic [7:0]         r_word_cnt;
  logic [7:0]         r_n;
  logic [23:0]        r_word;
  logic [CRC_W-1:0]   r_crc;

  logic               w_byte;
  logic               w_last;
  logic               w_wr_en;
  logic               w_commit;
  logic               w_rollback;
  logic               w_full;
  logic [ENTRY_W-1:0] w_wr_data;
  logic [ENTRY_W-1:0] w_rd_data;

  // Frame end is acted on one edge after it is sampled; bytes use the live qualifier.
  assign w_byte     = frame && data_ready;
  assign w_last     = (r_word_cnt == r_n);
  assign w_wr_en    = (r_state == S_WORDS) && r_frame && w_byte && (r_byte_idx == 2'd3);
  assign w_wr_data  = {w_last, data, r_word};
  assign w_commit   = (r_state == S_WAIT_END) && !r_frame;
  assign w_rollback = ((r_state == S_WORDS) || (r_state == S_CRC) ||
                       (r_state == S_DISCARD)) && !r_frame;

  assign busy     = (r_state != S_IDLE);
  assign out_data = w_rd_data[WORD_W-1:0];
  assign out_last = w_rd_data[WORD_W];

  maple_rx_fifo #(.ADDR_WIDTH(ADDR_WIDTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (w_wr_en),
    .i_wr_data  (w_wr_data),
    .i_commit   (w_commit),
    .i_rollback (w_rollback),
    .i_rd_en    (out_ready),
    .o_full     (w_full),
    .o_valid    (out_valid),
    .o_rd_data  (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_frame    <= 1'b0;
      r_byte_idx <= '0;
      r_word_cnt <= '0;
      r_n        <= '0;
      r_word     <= '0;
      r_crc      <= '0;
      pkt_done   <= 1'b0;
      pkt_ok     <= 1'b0;
      err_crc    <= 1'b0;
      err_len    <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      r_frame  <= frame;
      pkt_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (frame) begin
            r_state    <= S_WORDS;
            r_byte_idx <= '0;
            r_word_cnt <= '0;
            r_crc      <= '0;
            err_crc    <= 1'b0;
            err_len    <= 1'b0;
            err_ovf    <= 1'b0;
          end
        end
        S_WORDS: begin
          if (!r_frame) begin
            err_len  <= 1'b1;
            pkt_done <= 1'b1;
            pkt_ok   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (w_byte) begin
            r_crc      <= r_crc ^ data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == COUNT_BYTE && r_word_cnt == 8'd0) r_n <= data;
            case (r_byte_idx)
              2'd0:    r_word[7:0]   <= data;
              2'd1:    r_word[15:8]  <= data;
              2'd2:    r_word[23:16] <= data;
              default: ;
            endcase
            if (r_byte_idx == 2'd3) begin
              if (w_full) begin
                err_ovf <= 1'b1;
                r_state <= S_DISCARD;
              end else if (w_last) begin
                r_state <= S_CRC;
              end else begin
                r_word_cnt <= r_word_cnt + 8'd1;
              end
            end
          end
        end
        S_CRC: begin
          if (!r_frame) begin
            err_len  <= 1'b1;
            pkt_done <= 1'b1;
            pkt_ok   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (w_byte) begin
            if (data == r_crc) begin
              r_state <= S_WAIT_END;
            end else begin
              err_crc <= 1'b1;
              r_state <= S_DISCARD;
            end
          end
        end
        S_WAIT_END: begin
          if (!r_frame) begin
            pkt_done <= 1'b1;
            pkt_ok   <= 1'b1;
            r_state  <= S_IDLE;
          end else if (w_byte) begin
            err_len <= 1'b1;
            r_state <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (!r_frame) begin
            pkt_done <= 1'b1;
            pkt_ok   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
